// File: rtl/linear_regression_pkg.sv
// Types, width helpers and saturation shared by the linear-regression
// training and prediction stages.
package linear_regression_pkg;

    // Widest intermediate any caller hands to lr_saturate.
    localparam int SAT_W = 256;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_PREP   = 2'd1,
        ST_DIV    = 2'd2,
        ST_THETA0 = 2'd3
    } lr_state_t;

    function automatic int lr_sum_w(input int data_w, input int log2n);
        return data_w + log2n;
    endfunction

    function automatic int lr_sq_w(input int data_w, input int log2n);
        return 2 * data_w + log2n;
    endfunction

    function automatic int lr_num_w(input int data_w, input int log2n);
        return 2 * data_w + 2 * log2n + 1;
    endfunction

    // Clamp a sign-extended value to the signed range of data_w bits.
    function automatic logic signed [SAT_W-1:0] lr_saturate(
        input logic signed [SAT_W-1:0] v,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] hi;
        for (int i = 0; i < SAT_W; i++) hi[i] = (i < data_w - 1);
        if (v > hi) return hi;
        if (v < ~hi) return ~hi;
        return v;
    endfunction

endpackage

// File: rtl/lr_seq_divider.sv
// Signed restoring divider, one quotient bit per cycle, fixed latency of W
// cycles after start; quotient truncates toward zero, den==0 yields 0 + zero.
module lr_seq_divider #(
    parameter int W = 79
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] num,
    input  logic signed [W-1:0] den,
    output logic signed [W-1:0] quo,
    output logic                zero,
    output logic                busy,
    output logic                done
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     q_mag, d_mag, num_mag, den_mag;
    logic [W:0]       rem, rem_sh, trial;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    always_comb begin
        num_mag = num[W-1] ? $unsigned(-num) : $unsigned(num);
        den_mag = den[W-1] ? $unsigned(-den) : $unsigned(den);
        rem_sh  = {rem[W-1:0], q_mag[W-1]};
        trial   = rem_sh - {1'b0, d_mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            q_mag <= '0;
            d_mag <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            zero  <= 1'b0;
            busy  <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            q_mag <= num_mag;
            d_mag <= den_mag;
            cnt   <= CNT_W'(W);
            neg   <= num[W-1] ^ den[W-1];
            zero  <= (den == '0);
            busy  <= 1'b1;
        end else if (busy) begin
            cnt  <= cnt - CNT_W'(1);
            busy <= (cnt != CNT_W'(1));
            // A zero divisor still burns the full count so latency never varies.
            if (!zero) begin
                if (trial[W]) begin
                    rem   <= rem_sh;
                    q_mag <= {q_mag[W-2:0], 1'b0};
                end else begin
                    rem   <= trial;
                    q_mag <= {q_mag[W-2:0], 1'b1};
                end
            end
        end
    end

    // done marks the final step; quo/zero are valid from the following cycle.
    assign done = busy && (cnt == CNT_W'(1));
    assign quo  = zero ? '0 : (neg ? -$signed(q_mag) : $signed(q_mag));

endmodule

// File: rtl/linear_regression_training.sv
// Batch least-squares trainer: accumulates N_SAMPLES (x, y) pairs, then solves
// theta1 = num/den and theta0 = (Sy - theta1*Sx) >>> LOG2N, holding the last model.
module linear_regression_training
    import linear_regression_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_SAMPLES = 128
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic signed [DATA_W-1:0] i_samples_x_in,
    input  logic signed [DATA_W-1:0] i_samples_y_in,
    input  logic                     i_samples_vld,
    output logic                     o_samples_rdy,
    output logic signed [DATA_W-1:0] o_theta0_out,
    output logic signed [DATA_W-1:0] o_theta1_out,
    output logic                     o_theta1_out_vld,
    output logic                     o_degenerate
);
    localparam int LOG2N = $clog2(N_SAMPLES);
    localparam int SUM_W = lr_sum_w(DATA_W, LOG2N);
    localparam int SQ_W  = lr_sq_w(DATA_W, LOG2N);
    localparam int NUM_W = lr_num_w(DATA_W, LOG2N);
    localparam int T_W   = DATA_W + SUM_W + 1;

    lr_state_t state, state_nx;

    logic signed [SUM_W-1:0]    sx, sy;
    logic signed [SQ_W-1:0]     sxy, sxx;
    logic [LOG2N-1:0]           cnt;
    logic                       accept, div_start, div_done, div_zero, div_busy;
    logic signed [2*DATA_W-1:0] xw, yw, pxy, pxx;
    logic signed [NUM_W-1:0]    num, den, div_q;
    logic signed [T_W-1:0]      t0_full;
    logic signed [SAT_W-1:0]    q_wide, t0_wide;
    logic signed [DATA_W-1:0]   q_sat, t0_sat;

    always_comb begin
        accept  = (state == ST_ACCUM) && i_samples_vld;
        xw      = {{DATA_W{i_samples_x_in[DATA_W-1]}}, i_samples_x_in};
        yw      = {{DATA_W{i_samples_y_in[DATA_W-1]}}, i_samples_y_in};
        pxy     = xw * yw;
        pxx     = xw * xw;
        num     = (NUM_W'(sxy) <<< LOG2N) - NUM_W'(sx) * NUM_W'(sy);
        den     = (NUM_W'(sxx) <<< LOG2N) - NUM_W'(sx) * NUM_W'(sx);
        q_wide  = lr_saturate(SAT_W'(div_q), DATA_W);
        q_sat   = q_wide[DATA_W-1:0];
        t0_full = (T_W'(sy) - T_W'(q_sat) * T_W'(sx)) >>> LOG2N;
        t0_wide = lr_saturate(SAT_W'(t0_full), DATA_W);
        t0_sat  = t0_wide[DATA_W-1:0];
    end

    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        case (state)
            ST_ACCUM:  if (accept && (&cnt)) state_nx = ST_PREP;
            ST_PREP: begin
                div_start = 1'b1;
                state_nx  = ST_DIV;
            end
            ST_DIV:    if (div_done) state_nx = ST_THETA0;
            ST_THETA0: state_nx = ST_ACCUM;
            default:   state_nx = ST_ACCUM;
        endcase
    end

    lr_seq_divider #(.W(NUM_W)) u_div (
        .clk   (i_clock),
        .rst   (i_reset),
        .start (div_start),
        .num   (num),
        .den   (den),
        .quo   (div_q),
        .zero  (div_zero),
        .busy  (div_busy),
        .done  (div_done)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state            <= ST_ACCUM;
            sx               <= '0;
            sy               <= '0;
            sxy              <= '0;
            sxx              <= '0;
            cnt              <= '0;
            o_theta0_out     <= '0;
            o_theta1_out     <= '0;
            o_theta1_out_vld <= 1'b0;
            o_degenerate     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sx  <= sx + SUM_W'(i_samples_x_in);
                sy  <= sy + SUM_W'(i_samples_y_in);
                sxy <= sxy + SQ_W'(pxy);
                sxx <= sxx + SQ_W'(pxx);
                cnt <= cnt + LOG2N'(1);
            end
            // Publish the new model and start a fresh batch.
            if (state == ST_THETA0) begin
                o_theta1_out     <= q_sat;
                o_theta0_out     <= t0_sat;
                o_theta1_out_vld <= 1'b1;
                o_degenerate     <= div_zero;
                sx               <= '0;
                sy               <= '0;
                sxy              <= '0;
                sxx              <= '0;
                cnt              <= '0;
            end
        end
    end

    assign o_samples_rdy = (state == ST_ACCUM);

endmodule

// File: doc/linear_regression_training.md
# linear_regression_training

Training stage directly upstream of `linear_regression_prediction`. It accumulates a batch of N_SAMPLES signed (x, y) pairs, then solves the integer least-squares fit y = theta0 + theta1·x with a sequential divider. It presents theta0/theta1 plus a level valid on the same port names the prediction stage consumes. The outputs keep the last trained model while the next batch trains.

## Interface
- DATA_W, 32, width of x, y, theta0, theta1 (signed two's complement)
- N_SAMPLES, 128, batch size; power of two, ≥2
- LOG2N, $clog2(N_SAMPLES), derived, not overridable
- i_clock  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_samples_x_in  in  DATA_W  sample x
- i_samples_y_in  in  DATA_W  sample y
- i_samples_vld  in  1  sample valid; accepted when high and o_samples_rdy high
- o_samples_rdy  out  1  high in ACCUM state
- o_theta0_out  out  DATA_W  intercept
- o_theta1_out  out  DATA_W  slope
- o_theta1_out_vld  out  1  level; high once any batch has completed
- o_degenerate  out  1  last batch had zero x-variance

## Operation
- Reset values: o_samples_rdy=1, thetas=0, o_theta1_out_vld=0, o_degenerate=0, all sums/counters 0, state ACCUM.
- ACCUM: each accepted sample adds to Sx, Sy (DATA_W+LOG2N bits), Sxy, Sxx (2·DATA_W+LOG2N bits, signed) and increments the count. On the N_SAMPLES-th acceptance go to PREP.
- PREP (1 cycle):
  - num = (Sxy<<LOG2N) − Sx·Sy
  - den = (Sxx<<LOG2N) − Sx·Sx
  - NUM_W = 2·DATA_W+2·LOG2N+1 bits, signed; 79 at defaults.
- DIV (NUM_W cycles): restoring division on magnitudes, one quotient bit per cycle. Sign applied after; quotient truncates toward zero. Result saturates to the DATA_W signed range. den==0 skips the iteration count but still spends NUM_W cycles; the quotient is forced to 0 and the degenerate flag is set.
- THETA0 (1 cycle): t0 = (Sy − q·Sx) >>> LOG2N (arithmetic shift, floor), saturated to DATA_W.
- At THETA0 exit:
  - o_theta1_out=q, o_theta0_out=t0, o_theta1_out_vld=1, o_degenerate updated.
  - Sums and count cleared; return to ACCUM.
- Samples presented while o_samples_rdy=0 are ignored, not buffered.
- Thetas change only at THETA0 exit. Between batches they hold the previous model with vld still high.
- i_reset at any time (mid-accumulation, mid-division) returns to the reset values asynchronously. The partial batch is discarded.

## Timing
- The accepting edge of the last sample is E0. o_samples_rdy falls after E0.
- Thetas, vld and o_degenerate update at edge E0+NUM_W+2; o_samples_rdy rises at the same edge. Total is NUM_W+2 cycles (81 at defaults).
- A new sample is accepted from the first edge after rdy rises.
- Throughput: one sample per cycle in ACCUM.
- States: ACCUM→PREP→DIV→THETA0→ACCUM. No other transitions except reset.

## Structure
- Package `linear_regression_pkg`: state enum, width constants (accumulator widths, NUM_W as functions of DATA_W/LOG2N), saturate-to-DATA_W function. This package is shared with the prediction stage.
- Sub-module `lr_seq_divider`:
  - Parameterised signed restoring divider with start/done.
  - den==0 produces quotient 0 plus a zero flag.
  - Fixed latency of NUM_W cycles.
  - Reusable elsewhere.

## Test plan
All scenarios use N_SAMPLES=4 unless noted.
- x=1,2,3,4; y=5,7,9,11 -> theta1=2, theta0=3, degenerate=0, vld rises exactly NUM_W+2 edges after the 4th acceptance.
- x=0,1,2,3; y=10,8,6,4 -> theta1=−2, theta0=10 (negative slope, sign handling).
- x=1,2,3,4; y=0,1,1,3 -> num=18, den=20, theta1=0 (truncation), theta0=1.
- x=3,3,3,3; y=1,2,3,4 -> theta1=0, theta0=2, degenerate=1.
- Hold i_samples_vld=1 continuously across two batches -> samples during busy are ignored. The first model stays on the outputs with vld=1 until the second batch's update edge. The second batch contains only samples accepted after rdy rises.
- Assert i_reset mid-DIV -> all outputs return to reset values immediately and rdy=1. A fresh full batch then produces the correct model.
- N_SAMPLES=128 default, with the 128 x values of the prediction bench and y=2x+115313 -> theta1=2, theta0=115313. Feeding the prediction stage reproduces its expected outputs.
